// File: rtl/oled_draw_queue_pkg.sv
// Shared types and constants for the SSD1331 draw-request queue.
//   byte_t      - one command byte
//   draw_op_t   - high-level drawing operations (codes 5..7 are illegal)
//   draw_req_t  - one raw request as stored in the FIFO
//   OPC_*       - SSD1331 opcodes, CMD_* - byte-count codes for the controller
//   clamp/col_* - helpers used when formatting a request into a command image
package oled_draw_queue_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    OpFillEn = 3'd0,
    OpClear  = 3'd1,
    OpCopy   = 3'd2,
    OpLine   = 3'd3,
    OpRect   = 3'd4
  } draw_op_t;

  localparam byte_t OPC_LINE  = 8'h21;
  localparam byte_t OPC_RECT  = 8'h22;
  localparam byte_t OPC_COPY  = 8'h23;
  localparam byte_t OPC_CLEAR = 8'h25;
  localparam byte_t OPC_FILL  = 8'h26;

  localparam logic [3:0] CMD_2B  = 4'd0;
  localparam logic [3:0] CMD_5B  = 4'd1;
  localparam logic [3:0] CMD_7B  = 4'd2;
  localparam logic [3:0] CMD_8B  = 4'd3;
  localparam logic [3:0] CMD_11B = 4'd4;

  localparam byte_t COL_MAX = 8'd95;
  localparam byte_t ROW_MAX = 8'd63;

  // Op kept as raw bits so illegal codes survive the FIFO and can be reported.
  typedef struct packed {
    logic [2:0]  op;
    logic [6:0]  x0;
    logic [5:0]  y0;
    logic [6:0]  x1;
    logic [5:0]  y1;
    logic [6:0]  x2;
    logic [5:0]  y2;
    logic [15:0] col;
    logic [15:0] fill;
  } draw_req_t;

  function automatic byte_t clamp(input byte_t v, input byte_t max);
    return (v > max) ? max : v;
  endfunction

  // RGB565 -> three 6-bit colour bytes; 5-bit channels are left-aligned.
  function automatic byte_t col_r(input logic [15:0] c);
    return {2'b00, c[15:11], 1'b0};
  endfunction

  function automatic byte_t col_g(input logic [15:0] c);
    return {2'b00, c[10:5]};
  endfunction

  function automatic byte_t col_b(input logic [15:0] c);
    return {2'b00, c[4:0], 1'b0};
  endfunction

endpackage

// File: rtl/draw_req_fifo.sv
// Synchronous FIFO of raw draw requests.
//   clk, rst      - clock, asynchronous active-high reset
//   push, wdata   - write; ignored when full
//   pop, rdata    - read; rdata always shows the head entry, ignored when empty
//   full, empty   - status
//   count         - current number of entries (0..DEPTH)
module draw_req_fifo
  import oled_draw_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  draw_req_t              wdata,
  input  logic                   pop,
  output draw_req_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  draw_req_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/oled_draw_queue.sv
// Queues high-level drawing requests and issues them to the SSD1331 controller
// as an 11-byte command image (IR, IR[10] sent first) plus byte-count code (cmd).
//   clk, rst                - clock, asynchronous active-high reset
//   req_valid/req_ready     - request handshake (ready = FIFO not full)
//   req_op, req_x*/y*       - operation and coordinates (raw, clamped when loaded)
//   req_col, req_fill       - RGB565 outline and fill colours
//   rdy                     - controller ready; drops after exec, rises when done
//   exec                    - 1-cycle issue strobe
//   cmd, IR                 - command image, stable from load until the next load
//   busy                    - queue non-empty or a command in flight
//   err                     - 1-cycle pulse when an illegal op is dropped
module oled_draw_queue
  import oled_draw_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP_CYC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [6:0]   req_x0,
  input  logic [6:0]   req_x1,
  input  logic [6:0]   req_x2,
  input  logic [5:0]   req_y0,
  input  logic [5:0]   req_y1,
  input  logic [5:0]   req_y2,
  input  logic [15:0]  req_col,
  input  logic [15:0]  req_fill,
  input  logic         rdy,
  output logic         exec,
  output logic [3:0]   cmd,
  output byte_t [10:0] IR,
  output logic         busy,
  output logic         err
);

  localparam int unsigned GapW = $clog2(GAP_CYC + 2);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWaitLo, StWaitHi, StGap} state_t;

  state_t       state_q, state_d;
  byte_t [10:0] ir_q, ir_d, fmt_ir;
  logic [3:0]   cmd_q, cmd_d, fmt_cmd;
  logic         exec_q, exec_d, err_q, err_d, op_legal;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  draw_req_t              fifo_wdata, head;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  byte_t                  cx0, cx1, cx2, cy0, cy1, cy2;

  assign fifo_wdata = '{op: req_op, x0: req_x0, y0: req_y0, x1: req_x1, y1: req_y1,
                        x2: req_x2, y2: req_y2, col: req_col, fill: req_fill};

  draw_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_valid),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign cx0 = clamp({1'b0, head.x0}, COL_MAX);
  assign cx1 = clamp({1'b0, head.x1}, COL_MAX);
  assign cx2 = clamp({1'b0, head.x2}, COL_MAX);
  assign cy0 = clamp({2'b00, head.y0}, ROW_MAX);
  assign cy1 = clamp({2'b00, head.y1}, ROW_MAX);
  assign cy2 = clamp({2'b00, head.y2}, ROW_MAX);

  // Command image for the FIFO head; only consumed in StLoad.
  always_comb begin
    fmt_ir   = '0;
    fmt_cmd  = CMD_2B;
    op_legal = 1'b1;
    case (head.op)
      OpFillEn: begin
        fmt_ir[10:9] = {OPC_FILL, 7'b0, head.x0[0]};
        fmt_cmd      = CMD_2B;
      end
      OpClear: begin
        fmt_ir[10:6] = {OPC_CLEAR, cx0, cy0, cx1, cy1};
        fmt_cmd      = CMD_5B;
      end
      OpCopy: begin
        fmt_ir[10:4] = {OPC_COPY, cx0, cy0, cx1, cy1, cx2, cy2};
        fmt_cmd      = CMD_7B;
      end
      OpLine: begin
        fmt_ir[10:3] = {OPC_LINE, cx0, cy0, cx1, cy1,
                        col_r(head.col), col_g(head.col), col_b(head.col)};
        fmt_cmd      = CMD_8B;
      end
      OpRect: begin
        fmt_ir       = {OPC_RECT, cx0, cy0, cx1, cy1,
                        col_r(head.col), col_g(head.col), col_b(head.col),
                        col_r(head.fill), col_g(head.fill), col_b(head.fill)};
        fmt_cmd      = CMD_11B;
      end
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cmd_d     = cmd_q;
    exec_d    = 1'b0;
    err_d     = 1'b0;
    gap_cnt_d = gap_cnt_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StLoad;
      end
      StLoad: begin
        fifo_pop = 1'b1;
        if (op_legal) begin
          ir_d    = fmt_ir;
          cmd_d   = fmt_cmd;
          state_d = StIssue;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (rdy) begin
          exec_d  = 1'b1;
          state_d = StWaitLo;
        end
      end
      // rdy may still be high from before exec; only its fall marks acceptance.
      StWaitLo: begin
        if (!rdy) state_d = StWaitHi;
      end
      StWaitHi: begin
        if (rdy) begin
          if (GAP_CYC > 0) begin
            gap_cnt_d = '0;
            state_d   = StGap;
          end else begin
            state_d   = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      cmd_q     <= '0;
      exec_q    <= 1'b0;
      err_q     <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cmd_q     <= cmd_d;
      exec_q    <= exec_d;
      err_q     <= err_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign req_ready = !fifo_full;
  assign exec      = exec_q;
  assign err       = err_q;
  assign cmd       = cmd_q;
  assign IR        = ir_q;
  assign busy      = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_oled_draw_queue.sv
// Directed bench for oled_draw_queue (DEPTH=8, GAP_CYC=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_oled_draw_queue;
  import oled_draw_queue_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [2:0]   req_op;
  logic [6:0]   req_x0, req_x1, req_x2;
  logic [5:0]   req_y0, req_y1, req_y2;
  logic [15:0]  req_col, req_fill;
  logic         rdy, exec, busy, err;
  logic [3:0]   cmd;
  logic [10:0][7:0] ir;

  int n_vec = 0;
  int n_bad = 0;
  int exec_cnt = 0;
  int err_cnt = 0;

  oled_draw_queue #(
    .DEPTH  (8),
    .GAP_CYC(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_x0   (req_x0),
    .req_x1   (req_x1),
    .req_x2   (req_x2),
    .req_y0   (req_y0),
    .req_y1   (req_y1),
    .req_y2   (req_y2),
    .req_col  (req_col),
    .req_fill (req_fill),
    .rdy      (rdy),
    .exec     (exec),
    .cmd      (cmd),
    .IR       (ir),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exec === 1'b1) exec_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic set_fields(input logic [2:0] op, input logic [6:0] x0, input logic [5:0] y0,
                            input logic [6:0] x1, input logic [5:0] y1, input logic [6:0] x2,
                            input logic [5:0] y2, input logic [15:0] col,
                            input logic [15:0] fill);
    req_op = op; req_x0 = x0; req_y0 = y0; req_x1 = x1; req_y1 = y1;
    req_x2 = x2; req_y2 = y2; req_col = col; req_fill = fill;
  endtask

  // One-cycle push; the request is accepted on the rising edge inside this task.
  task automatic push(input logic [2:0] op, input logic [6:0] x0, input logic [5:0] y0,
                      input logic [6:0] x1, input logic [5:0] y1, input logic [6:0] x2,
                      input logic [5:0] y2, input logic [15:0] col, input logic [15:0] fill);
    @(negedge clk);
    set_fields(op, x0, y0, x1, y1, x2, y2, col, fill);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Plays the controller for one command: rdy high, wait for exec (bounded),
  // capture the image, drop rdy for three cycles, raise it again.
  // lat = rising edges between the call's reference edge and exec.
  task automatic serve_one(output bit ok, output logic [87:0] got_ir, output logic [3:0] got_cmd,
                           output int lat);
    ok = 1'b0; lat = 0; got_ir = '0; got_cmd = '0;
    rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exec === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    if (ok) begin
      got_ir  = ir;
      got_cmd = cmd;
      rdy = 1'b0;
      repeat (3) @(negedge clk);
      rdy = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; req_valid = 1'b0;
    set_fields(3'd0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    n_vec++; if (exec !== 1'b0) begin n_bad++; $display("FAIL reset_exec got %b want 0", exec); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_vec++; if (cmd !== 4'd0) begin n_bad++; $display("FAIL reset_cmd got %0d want 0", cmd); end
    n_vec++; if (ir !== 88'h0) begin n_bad++; $display("FAIL reset_ir got %h want 0", ir); end
    n_vec++; if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rect();
    bit ok; logic [87:0] gi; logic [3:0] gc; int lat; int e0;
    rdy = 1'b1; e0 = exec_cnt;
    push(OpRect, 7'd0, 6'd0, 7'd95, 6'd63, 7'd0, 6'd0, 16'hF800, 16'h001F);
    serve_one(ok, gi, gc, lat);
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rect_exec_seen got %b want 1", ok); end
    n_vec++; if (lat != 3) begin n_bad++; $display("FAIL rect_latency got %0d want 3", lat); end
    n_vec++; if (gi !== 88'h22_00_00_5F_3F_3E_00_00_00_00_3E) begin
      n_bad++; $display("FAIL rect_ir got %h want 2200005f3f3e000000003e", gi);
    end
    n_vec++; if (gc !== 4'd4) begin n_bad++; $display("FAIL rect_cmd got %0d want 4", gc); end
    repeat (5) @(negedge clk);
    n_vec++; if (exec_cnt - e0 != 1) begin
      n_bad++; $display("FAIL rect_exec_count got %0d want 1", exec_cnt - e0);
    end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rect_busy_after got %b want 0", busy); end
  endtask

  // x1=120 exceeds the last column; rows are 6 bits wide so 63 is the largest row.
  task automatic test_line();
    bit ok; logic [87:0] gi; logic [3:0] gc; int lat;
    push(OpLine, 7'd10, 6'd5, 7'd120, 6'd63, 7'd0, 6'd0, 16'h07E0, 16'h0000);
    serve_one(ok, gi, gc, lat);
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL line_exec_seen got %b want 1", ok); end
    n_vec++; if (gi !== 88'h21_0A_05_5F_3F_00_3F_00_00_00_00) begin
      n_bad++; $display("FAIL line_ir got %h want 210a055f3f003f00000000", gi);
    end
    n_vec++; if (gc !== 4'd3) begin n_bad++; $display("FAIL line_cmd got %0d want 3", gc); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_copy();
    bit ok; logic [87:0] gi; logic [3:0] gc; int lat;
    push(OpCopy, 7'd1, 6'd2, 7'd100, 6'd3, 7'd4, 6'd5, 16'hFFFF, 16'hFFFF);
    serve_one(ok, gi, gc, lat);
    n_vec++; if (gi !== 88'h23_01_02_5F_03_04_05_00_00_00_00) begin
      n_bad++; $display("FAIL copy_ir got %h want 2301025f030405 then zeros (ok=%b)", gi, ok);
    end
    n_vec++; if (gc !== 4'd2) begin n_bad++; $display("FAIL copy_cmd got %0d want 2", gc); end
    repeat (3) @(negedge clk);
  endtask

  // One command parks in ISSUE (rdy low) so the FIFO itself can fill to 8.
  task automatic test_full();
    bit ok; logic [87:0] gi; logic [3:0] gc; int lat; int acc; logic last_ready; int e0;
    logic [7:0] want_x0;
    rdy = 1'b0; e0 = exec_cnt;
    push(OpClear, 7'h50, 6'd1, 7'd2, 6'd3, 7'd0, 6'd0, 16'h0, 16'h0);
    repeat (6) @(negedge clk);
    acc = 0; last_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_fields(OpClear, 7'(i + 1), 6'd1, 7'd2, 6'd3, 7'd0, 6'd0, 16'h0, 16'h0);
      req_valid = 1'b1;
      last_ready = req_ready;
      if (req_ready === 1'b1) acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (acc != 8) begin n_bad++; $display("FAIL full_accepted got %0d want 8", acc); end
    n_vec++; if (last_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_ready_9th got %b want 0", last_ready);
    end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy got %b want 1", busy); end
    for (int k = 0; k < 9; k++) begin
      serve_one(ok, gi, gc, lat);
      want_x0 = (k == 0) ? 8'h50 : 8'(k);
      n_vec++; if (ok !== 1'b1 || gi[79:72] !== want_x0) begin
        n_bad++; $display("FAIL full_order_%0d got x0=%h ok=%b want x0=%h", k, gi[79:72], ok, want_x0);
      end
    end
    repeat (10) @(negedge clk);
    n_vec++; if (exec_cnt - e0 != 9) begin
      n_bad++; $display("FAIL full_exec_count got %0d want 9", exec_cnt - e0);
    end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_end got %b want 0", busy); end
  endtask

  task automatic test_illegal();
    bit ok; logic [87:0] gi; logic [3:0] gc; int lat; int e0; int r0;
    rdy = 1'b1; e0 = exec_cnt; r0 = err_cnt;
    push(3'd6, 7'd9, 6'd9, 7'd9, 6'd9, 7'd9, 6'd9, 16'h1234, 16'h5678);
    push(OpClear, 7'd1, 6'd2, 7'd3, 6'd4, 7'd0, 6'd0, 16'h0, 16'h0);
    serve_one(ok, gi, gc, lat);
    n_vec++; if (gi !== 88'h25_01_02_03_04_00_00_00_00_00_00) begin
      n_bad++; $display("FAIL illegal_clear_ir got %h want 2501020304 then zeros (ok=%b)", gi, ok);
    end
    n_vec++; if (gc !== 4'd1) begin n_bad++; $display("FAIL illegal_clear_cmd got %0d want 1", gc); end
    repeat (5) @(negedge clk);
    n_vec++; if (err_cnt - r0 != 1) begin
      n_bad++; $display("FAIL illegal_err_cycles got %0d want 1", err_cnt - r0);
    end
    n_vec++; if (exec_cnt - e0 != 1) begin
      n_bad++; $display("FAIL illegal_exec_count got %0d want 1", exec_cnt - e0);
    end
  endtask

  task automatic test_hold();
    bit ok; logic [87:0] gi; logic [3:0] gc; int lat; int e0; int bad; bit seen;
    logic [87:0] ir0;
    rdy = 1'b1; e0 = exec_cnt; seen = 1'b0; ir0 = '0;
    push(OpFillEn, 7'd1, 6'd0, 7'd0, 6'd0, 7'd0, 6'd0, 16'h0, 16'h0);
    push(OpClear, 7'd10, 6'd11, 7'd12, 6'd13, 7'd0, 6'd0, 16'h0, 16'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exec === 1'b1) begin seen = 1'b1; break; end
    end
    ir0 = ir;
    n_vec++; if (seen !== 1'b1 || ir0 !== {8'h26, 8'h01, 72'h0}) begin
      n_bad++; $display("FAIL hold_fill_ir got %h seen=%b want 2601 then zeros", ir0, seen);
    end
    n_vec++; if (cmd !== 4'd0) begin n_bad++; $display("FAIL hold_fill_cmd got %0d want 0", cmd); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (exec !== 1'b0 || ir !== ir0) bad++;
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    n_vec++; if (exec_cnt - e0 != 1) begin
      n_bad++; $display("FAIL hold_exec_count got %0d want 1", exec_cnt - e0);
    end
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    serve_one(ok, gi, gc, lat);
    n_vec++; if (ok !== 1'b1 || gi[87:48] !== 40'h25_0A_0B_0C_0D) begin
      n_bad++; $display("FAIL hold_second got %h ok=%b want 250a0b0c0d", gi[87:48], ok);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen; int e0;
    rdy = 1'b1; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(OpClear, 7'(20 + i), 6'd1, 7'd2, 6'd3, 7'd0, 6'd0, 16'h0, 16'h0);
    end
    for (int i = 0; i < 40; i++) begin
      if (exec === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (seen !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre got seen=%b busy=%b want 1 1", seen, busy);
    end
    rst = 1'b1;
    #1;
    n_vec++; if (exec !== 1'b0) begin n_bad++; $display("FAIL rstmid_exec got %b want 0", exec); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_vec++; if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_ready got %b want 1", req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; rdy = 1'b1; e0 = exec_cnt;
    repeat (20) @(negedge clk);
    n_vec++; if (exec_cnt - e0 != 0) begin
      n_bad++; $display("FAIL rstmid_no_exec got %0d want 0", exec_cnt - e0);
    end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_end got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_rect();
    test_line();
    test_copy();
    test_full();
    test_illegal();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
